// File: rtl/memory_cycle_lsu.sv
// MEM stage of the RV32I pipeline: issues loads/stores on a req/ack bus, stalls
// the pipe while an access is outstanding and formats load data into MEM/WB.
module memory_cycle_lsu #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_insn_vldM,
   input  logic        i_RegWriteM,
   input  logic        i_MemWriteM,
   input  logic [1:0]  i_ResultSrcM,
   input  logic [2:0]  i_funct3M,
   input  logic [4:0]  i_RD_ADDR_M,
   input  logic [31:0] i_PCPlus4M,
   input  logic [31:0] i_ALU_ResultM,
   input  logic [31:0] i_WriteDataM,
   output logic        o_stall,
   output logic        o_dmem_req,
   output logic        o_dmem_we,
   output logic [31:0] o_dmem_addr,
   output logic [31:0] o_dmem_wdata,
   output logic [3:0]  o_dmem_be,
   input  logic        i_dmem_ack,
   input  logic [31:0] i_dmem_rdata,
   output logic        o_misaligned,
   output logic        o_bus_err,
   output logic        o_insn_vldW,
   output logic        o_RegWriteW,
   output logic [1:0]  o_ResultSrcW,
   output logic [4:0]  o_RD_ADDR_W,
   output logic [31:0] o_PCPlus4W,
   output logic [31:0] o_ALU_ResultW,
   output logic [31:0] o_ReadDataW
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

   state_t           state, state_next;
   logic [CNT_W-1:0] count;
   logic             acc, misaligned, start, ack_done, timed_out;
   logic [3:0]       store_be;
   logic [31:0]      store_wdata, load_data, byte_word;
   logic             mw_vld, mw_regwrite, mis_next, err_next;
   logic [31:0]      mw_rdata;

   assign acc       = i_insn_vldM & (i_MemWriteM | (i_ResultSrcM == 2'b01));
   assign start     = (state == IDLE) & acc & ~misaligned;
   assign ack_done  = (state == BUSY) & i_dmem_ack;
   assign timed_out = (TIMEOUT != 0) && (state == BUSY) && !i_dmem_ack && (count == LAST_CNT);

   always_comb begin
      misaligned  = 1'b0;
      store_be    = 4'hF;
      store_wdata = i_WriteDataM;
      case (i_funct3M[1:0])
         2'b00: begin
            store_be    = 4'b0001 << i_ALU_ResultM[1:0];
            store_wdata = {4{i_WriteDataM[7:0]}};
         end
         2'b01: begin
            misaligned  = acc & i_ALU_ResultM[0];
            store_be    = 4'b0011 << {i_ALU_ResultM[1], 1'b0};
            store_wdata = {2{i_WriteDataM[15:0]}};
         end
         default: misaligned = acc & (i_ALU_ResultM[1:0] != 2'b00);
      endcase
   end

   // Shift the addressed byte/half down to lane 0, then extend by funct3.
   always_comb begin
      byte_word = i_dmem_rdata >> {i_ALU_ResultM[1:0], 3'b000};
      case (i_funct3M)
         3'b000:  load_data = {{24{byte_word[7]}}, byte_word[7:0]};
         3'b100:  load_data = {24'h0, byte_word[7:0]};
         3'b001:  load_data = {{16{byte_word[15]}}, byte_word[15:0]};
         3'b101:  load_data = {16'h0, byte_word[15:0]};
         default: load_data = i_dmem_rdata;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = BUSY;
         BUSY:    if (ack_done || timed_out) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Stall covers the issue cycle and every waiting BUSY cycle, but not the completing one.
   always_comb begin
      o_stall     = start | ((state == BUSY) & ~i_dmem_ack & ~timed_out);
      mw_vld      = 1'b0;
      mw_regwrite = 1'b0;
      mw_rdata    = 32'h0;
      mis_next    = 1'b0;
      err_next    = 1'b0;
      if (state == IDLE) begin
         if (i_insn_vldM && !start) begin
            mw_vld      = 1'b1;
            mw_regwrite = i_RegWriteM & ~misaligned;
            mis_next    = misaligned;
         end
      end else if (ack_done) begin
         mw_vld      = 1'b1;
         mw_regwrite = i_RegWriteM;
         mw_rdata    = load_data;
      end else if (timed_out) begin
         mw_vld   = 1'b1;
         err_next = 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_dmem_req   <= 1'b0;
         o_dmem_we    <= 1'b0;
         o_dmem_addr  <= 32'h0;
         o_dmem_wdata <= 32'h0;
         o_dmem_be    <= 4'h0;
         count        <= '0;
      end else if (start) begin
         o_dmem_req   <= 1'b1;
         o_dmem_we    <= i_MemWriteM;
         o_dmem_addr  <= {i_ALU_ResultM[31:2], 2'b00};
         o_dmem_wdata <= i_MemWriteM ? store_wdata : 32'h0;
         o_dmem_be    <= i_MemWriteM ? store_be : 4'hF;
         count        <= '0;
      end else if (state == BUSY) begin
         if (ack_done || timed_out) o_dmem_req <= 1'b0;
         else                       count      <= count + 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_insn_vldW   <= 1'b0;
         o_RegWriteW   <= 1'b0;
         o_ResultSrcW  <= 2'b00;
         o_RD_ADDR_W   <= 5'd0;
         o_PCPlus4W    <= 32'h0;
         o_ALU_ResultW <= 32'h0;
         o_ReadDataW   <= 32'h0;
         o_misaligned  <= 1'b0;
         o_bus_err     <= 1'b0;
      end else begin
         o_insn_vldW   <= mw_vld;
         o_RegWriteW   <= mw_regwrite;
         o_ResultSrcW  <= mw_vld ? i_ResultSrcM : 2'b00;
         o_RD_ADDR_W   <= mw_vld ? i_RD_ADDR_M : 5'd0;
         o_PCPlus4W    <= mw_vld ? i_PCPlus4M : 32'h0;
         o_ALU_ResultW <= mw_vld ? i_ALU_ResultM : 32'h0;
         o_ReadDataW   <= mw_rdata;
         o_misaligned  <= mis_next;
         o_bus_err     <= err_next;
      end
   end

endmodule

// File: tb/tb_memory_cycle_lsu.sv
// Directed bench for memory_cycle_lsu with a 4-cycle timeout; inputs change 1ns
// after each rising edge and outputs are sampled mid-cycle.
module tb_memory_cycle_lsu;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_insn_vldM, i_RegWriteM, i_MemWriteM;
   logic [1:0]  i_ResultSrcM;
   logic [2:0]  i_funct3M;
   logic [4:0]  i_RD_ADDR_M;
   logic [31:0] i_PCPlus4M, i_ALU_ResultM, i_WriteDataM;
   logic        o_stall, o_dmem_req, o_dmem_we;
   logic [31:0] o_dmem_addr, o_dmem_wdata;
   logic [3:0]  o_dmem_be;
   logic        i_dmem_ack;
   logic [31:0] i_dmem_rdata;
   logic        o_misaligned, o_bus_err, o_insn_vldW, o_RegWriteW;
   logic [1:0]  o_ResultSrcW;
   logic [4:0]  o_RD_ADDR_W;
   logic [31:0] o_PCPlus4W, o_ALU_ResultW, o_ReadDataW;

   int compared   = 0;
   int mismatched = 0;

   memory_cycle_lsu #(.TIMEOUT(4), .CNT_W(8)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_insn_vldM(i_insn_vldM), .i_RegWriteM(i_RegWriteM), .i_MemWriteM(i_MemWriteM),
      .i_ResultSrcM(i_ResultSrcM), .i_funct3M(i_funct3M), .i_RD_ADDR_M(i_RD_ADDR_M),
      .i_PCPlus4M(i_PCPlus4M), .i_ALU_ResultM(i_ALU_ResultM), .i_WriteDataM(i_WriteDataM),
      .o_stall(o_stall), .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
      .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata), .o_dmem_be(o_dmem_be),
      .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata),
      .o_misaligned(o_misaligned), .o_bus_err(o_bus_err),
      .o_insn_vldW(o_insn_vldW), .o_RegWriteW(o_RegWriteW), .o_ResultSrcW(o_ResultSrcW),
      .o_RD_ADDR_W(o_RD_ADDR_W), .o_PCPlus4W(o_PCPlus4W), .o_ALU_ResultW(o_ALU_ResultW),
      .o_ReadDataW(o_ReadDataW)
   );

   always #5 i_clk = ~i_clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic vld, input logic rw, input logic mw, input logic [1:0] rsrc,
                                input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] addr,
                                input logic [31:0] wd);
      i_insn_vldM   = vld;
      i_RegWriteM   = rw;
      i_MemWriteM   = mw;
      i_ResultSrcM  = rsrc;
      i_funct3M     = f3;
      i_RD_ADDR_M   = rd;
      i_PCPlus4M    = 32'h0000_0040;
      i_ALU_ResultM = addr;
      i_WriteDataM  = wd;
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      i_rst_n      = 1'b0;
      i_dmem_ack   = 1'b0;
      i_dmem_rdata = 32'h0;
      applyStimulus(0, 0, 0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0);
      #23;
      checkOutput("rst_req", {31'h0, o_dmem_req}, 32'h0);
      checkOutput("rst_stall", {31'h0, o_stall}, 32'h0);
      checkOutput("rst_vldW", {31'h0, o_insn_vldW}, 32'h0);
      checkOutput("rst_aluW", o_ALU_ResultW, 32'h0);
      i_rst_n = 1'b1;

      // ADD x5 = 0x1234
      tick();
      applyStimulus(1, 1, 0, 2'b00, 3'b000, 5'd5, 32'h0000_1234, 32'h0);
      #2 checkOutput("add_stall", {31'h0, o_stall}, 32'h0);
      tick();
      applyStimulus(0, 0, 0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0);
      #2;
      checkOutput("add_regwW", {31'h0, o_RegWriteW}, 32'h1);
      checkOutput("add_rdW", {27'h0, o_RD_ADDR_W}, 32'd5);
      checkOutput("add_aluW", o_ALU_ResultW, 32'h0000_1234);
      checkOutput("add_req", {31'h0, o_dmem_req}, 32'h0);

      // SB a=0x103 d=0xAB, ack on the second bus cycle
      tick();
      applyStimulus(1, 0, 1, 2'b00, 3'b000, 5'd0, 32'h0000_0103, 32'h0000_00AB);
      #2 checkOutput("sb_stall0", {31'h0, o_stall}, 32'h1);
      tick();
      #2;
      checkOutput("sb_stall1", {31'h0, o_stall}, 32'h1);
      checkOutput("sb_req", {31'h0, o_dmem_req}, 32'h1);
      checkOutput("sb_be", {28'h0, o_dmem_be}, 32'h8);
      checkOutput("sb_wdata", o_dmem_wdata, 32'hABAB_ABAB);
      checkOutput("sb_addr", o_dmem_addr, 32'h0000_0100);
      checkOutput("sb_we", {31'h0, o_dmem_we}, 32'h1);
      checkOutput("sb_bubble", {31'h0, o_insn_vldW}, 32'h0);
      tick();
      i_dmem_ack = 1'b1;
      #2 checkOutput("sb_stall2", {31'h0, o_stall}, 32'h0);
      tick();
      i_dmem_ack = 1'b0;
      applyStimulus(0, 0, 0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0);
      #2;
      checkOutput("sb_req_off", {31'h0, o_dmem_req}, 32'h0);
      checkOutput("sb_vldW", {31'h0, o_insn_vldW}, 32'h1);

      // LH a=0x102, three wait cycles, ack coincides with the timeout count
      tick();
      applyStimulus(1, 1, 0, 2'b01, 3'b001, 5'd7, 32'h0000_0102, 32'h0);
      tick();
      #2;
      checkOutput("lh_be", {28'h0, o_dmem_be}, 32'hF);
      checkOutput("lh_we", {31'h0, o_dmem_we}, 32'h0);
      tick();
      tick();
      #2 checkOutput("lh_stall_w3", {31'h0, o_stall}, 32'h1);
      tick();
      i_dmem_ack   = 1'b1;
      i_dmem_rdata = 32'h8001_0000;
      #2 checkOutput("lh_stall_ack", {31'h0, o_stall}, 32'h0);
      tick();
      i_dmem_ack = 1'b0;
      applyStimulus(0, 0, 0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0);
      #2;
      checkOutput("lh_rdataW", o_ReadDataW, 32'hFFFF_8001);
      checkOutput("lh_regwW", {31'h0, o_RegWriteW}, 32'h1);
      checkOutput("lh_rdW", {27'h0, o_RD_ADDR_W}, 32'd7);
      checkOutput("lh_buserr", {31'h0, o_bus_err}, 32'h0);

      // LHU, zero-wait memory
      tick();
      applyStimulus(1, 1, 0, 2'b01, 3'b101, 5'd7, 32'h0000_0102, 32'h0);
      tick();
      i_dmem_ack = 1'b1;
      #2 checkOutput("lhu_stall", {31'h0, o_stall}, 32'h0);
      tick();
      i_dmem_ack = 1'b0;
      applyStimulus(0, 0, 0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0);
      #2 checkOutput("lhu_rdataW", o_ReadDataW, 32'h0000_8001);

      // LW a=0x101 is misaligned
      tick();
      applyStimulus(1, 1, 0, 2'b01, 3'b010, 5'd9, 32'h0000_0101, 32'h0);
      #2 checkOutput("mis_stall", {31'h0, o_stall}, 32'h0);
      tick();
      applyStimulus(0, 0, 0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0);
      #2;
      checkOutput("mis_req", {31'h0, o_dmem_req}, 32'h0);
      checkOutput("mis_pulse", {31'h0, o_misaligned}, 32'h1);
      checkOutput("mis_regwW", {31'h0, o_RegWriteW}, 32'h0);
      checkOutput("mis_vldW", {31'h0, o_insn_vldW}, 32'h1);
      tick();
      #2 checkOutput("mis_pulse_end", {31'h0, o_misaligned}, 32'h0);

      // Load never acked: abort after 4 BUSY cycles
      tick();
      applyStimulus(1, 1, 0, 2'b01, 3'b010, 5'd3, 32'h0000_0200, 32'h0);
      for (int i = 0; i < 4; i++) begin
         tick();
         #2;
         checkOutput($sformatf("to_req%0d", i), {31'h0, o_dmem_req}, 32'h1);
         checkOutput($sformatf("to_stall%0d", i), {31'h0, o_stall}, (i == 3) ? 32'h0 : 32'h1);
      end
      tick();
      applyStimulus(0, 0, 0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0);
      #2;
      checkOutput("to_req_off", {31'h0, o_dmem_req}, 32'h0);
      checkOutput("to_buserr", {31'h0, o_bus_err}, 32'h1);
      checkOutput("to_regwW", {31'h0, o_RegWriteW}, 32'h0);
      checkOutput("to_vldW", {31'h0, o_insn_vldW}, 32'h1);
      tick();
      #2;
      checkOutput("to_buserr_end", {31'h0, o_bus_err}, 32'h0);
      checkOutput("to_idle_stall", {31'h0, o_stall}, 32'h0);

      // Reset while BUSY, stale ack afterwards must be ignored
      tick();
      applyStimulus(1, 1, 0, 2'b01, 3'b010, 5'd4, 32'h0000_0300, 32'h0);
      tick();
      #2 checkOutput("rb_req", {31'h0, o_dmem_req}, 32'h1);
      i_rst_n = 1'b0;
      applyStimulus(0, 0, 0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0);
      #1;
      checkOutput("rb_req_rst", {31'h0, o_dmem_req}, 32'h0);
      checkOutput("rb_addr_rst", o_dmem_addr, 32'h0);
      checkOutput("rb_stall_rst", {31'h0, o_stall}, 32'h0);
      #4 i_rst_n = 1'b1;
      tick();
      i_dmem_ack   = 1'b1;
      i_dmem_rdata = 32'hDEAD_BEEF;
      #2 checkOutput("rb_stall_ack", {31'h0, o_stall}, 32'h0);
      tick();
      i_dmem_ack = 1'b0;
      #2;
      checkOutput("rb_req_after", {31'h0, o_dmem_req}, 32'h0);
      checkOutput("rb_vldW", {31'h0, o_insn_vldW}, 32'h0);
      checkOutput("rb_rdataW", o_ReadDataW, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
